// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-port arbiter in front of a single-port synchronous memory. One access
//   is in flight at a time: GNT cycle (IDLE) -> ACCESS -> RDWAIT (reads only).
//
//   Build option:
//     MEM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins a tie, no pointer.
//                            undefined : round-robin with a last-grant pointer.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req0/1, we0/1         request and write enable per port
//     addr0/1, wdata0/1     request address and write data per port
//     gnt0/1                combinational grant pulse (IDLE only)
//     rvalid0/1, rdata      read return, one cycle, shared data bus
//     mem_cs, mem_we        memory strobes (ACCESS only)
//     mem_addr, mem_wdata   latched access address/data
//     mem_rdata             memory read data, valid the cycle after a read
//     busy                  state is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                port_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                win_s;
    logic                grant_s;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic                last_r;
`endif

    // Arbitration: pick the winning port index and qualify the grant.
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            // Port that was not granted most recently wins the tie.
            win_s = ~last_r;
`endif
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        // rst_n gating keeps the combinational grant at 0 while in reset.
        grant_s = (state_r == ST_IDLE) && (req0 || req1) && rst_n;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the winning request at the end of the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_r  <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (grant_s) begin
            port_r  <= win_s;
            we_r    <= win_s ? we1    : we0;
            addr_r  <= win_s ? addr1  : addr0;
            wdata_r <= win_s ? wdata1 : wdata0;
        end else begin
            port_r  <= port_r;
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Last-grant pointer; resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (grant_s) begin
            last_r <= win_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // Next-state and output decode.
    always_comb begin
        state_nxt_s = state_r;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rvalid0     = 1'b0;
        rvalid1     = 1'b0;
        rdata       = '0;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = addr_r;
        mem_wdata   = wdata_r;
        busy        = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                gnt0 = grant_s && !win_s;
                gnt1 = grant_s && win_s;
                if (grant_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                mem_cs = 1'b1;
                mem_we = we_r;
                if (we_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                rvalid0     = !port_r;
                rvalid1     = port_r;
                rdata       = mem_rdata;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A transaction-level model (grant cycle,
//   fixed latencies, a word array for memory contents) predicts every output
//   each cycle; a handful of literal checks pin the model to known values.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int tests;
    int fails;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the DUT.
    logic [DW-1:0] bmem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_cs && mem_we) bmem[mem_addr] <= mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= bmem[mem_addr];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int            cyc;
    int            free_at;
    bit            last_port;
    bit            t_valid, t_port, t_we;
    int            t_cyc;
    logic [DW-1:0] t_rdata;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] model_mem [0:(1<<AW)-1];

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        bit idle, any, w, e_g0, e_g1, e_cs, e_we, e_rv0, e_rv1;
        if (!rst_n) begin
            chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
            chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
            chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_strobes", {30'd0, mem_cs, mem_we}, 32'd0);
            chk("rst_addr", {25'd0, mem_addr}, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            free_at   = 0;
            last_port = 1'b1;
            t_valid   = 1'b0;
            lat_addr  = '0;
            lat_wdata = '0;
        end else begin
            idle = (cyc >= free_at);
            any  = req0 || req1;
            if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = (last_port == 1'b1) ? 1'b0 : 1'b1;
`endif
            end else begin
                w = req1;
            end
            e_g0  = idle && any && !w;
            e_g1  = idle && any && w;
            e_cs  = t_valid && (cyc == t_cyc + 1);
            e_we  = e_cs && t_we;
            e_rv0 = t_valid && !t_we && (cyc == t_cyc + 2) && !t_port;
            e_rv1 = t_valid && !t_we && (cyc == t_cyc + 2) && t_port;
            chk("gnt0", {31'd0, gnt0}, {31'd0, e_g0});
            chk("gnt1", {31'd0, gnt1}, {31'd0, e_g1});
            chk("mem_cs", {31'd0, mem_cs}, {31'd0, e_cs});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
            chk("rvalid0", {31'd0, rvalid0}, {31'd0, e_rv0});
            chk("rvalid1", {31'd0, rvalid1}, {31'd0, e_rv1});
            chk("busy", {31'd0, busy}, {31'd0, !idle});
            chk("mem_addr", {25'd0, mem_addr}, {25'd0, lat_addr});
            chk("mem_wdata", mem_wdata, lat_wdata);
            if (e_rv0 || e_rv1) chk("rdata", rdata, t_rdata);
            if (e_g0 || e_g1) begin
                t_valid   = 1'b1;
                t_cyc     = cyc;
                t_port    = w;
                t_we      = w ? we1 : we0;
                lat_addr  = w ? addr1 : addr0;
                lat_wdata = w ? wdata1 : wdata0;
                if (t_we) begin
                    model_mem[lat_addr] = lat_wdata;
                    free_at = cyc + 2;
                end else begin
                    t_rdata = model_mem[lat_addr];
                    free_at = cyc + 3;
                end
                last_port = w;
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        @(posedge clk); #1;
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) got = 1'b1;
        end
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    typedef struct { bit p; bit w; logic [AW-1:0] a; logic [DW-1:0] d; } vec_t;
    vec_t vecs [8];

    bit log_q [$];
    bit exp_order [6];
    int nlog;
    bit saw_g1;

    initial begin
        tests = 0; fails = 0; cyc = 0; free_at = 0; last_port = 1'b1;
        t_valid = 1'b0; t_cyc = 0; t_port = 1'b0; t_we = 1'b0; t_rdata = '0;
        lat_addr = '0; lat_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            bmem[i] = '0;
            model_mem[i] = '0;
        end
        mem_rdata = '0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Port 0 write of DEADBEEF to address 5.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h05; wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        chk("lit_w_gnt0", {31'd0, gnt0}, 32'd1);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("lit_w_cs_we", {30'd0, mem_cs, mem_we}, 32'd3);
        chk("lit_w_addr", {25'd0, mem_addr}, 32'h05);
        chk("lit_w_data", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("lit_w_busy", {31'd0, busy}, 32'd0);

        // Port 1 read of address 5.
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'h05;
        @(negedge clk);
        chk("lit_r_gnt1", {31'd0, gnt1}, 32'd1);
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        chk("lit_r_cs_we", {30'd0, mem_cs, mem_we}, 32'd2);
        @(negedge clk);
        chk("lit_r_rvalid", {30'd0, rvalid1, rvalid0}, 32'd2);
        chk("lit_r_rdata", rdata, 32'hDEADBEEF);

        // Directed vectors: address/data extremes, back-to-back requests while busy.
        vecs[0] = '{1'b0, 1'b1, 7'h00, 32'hFFFFFFFF};
        vecs[1] = '{1'b1, 1'b1, 7'h7F, 32'h12345678};
        vecs[2] = '{1'b0, 1'b0, 7'h7F, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 7'h00, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 7'h2A, 32'hA5A5A5A5};
        vecs[5] = '{1'b1, 1'b0, 7'h2A, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 7'h05, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 7'h11, 32'h0};
        foreach (vecs[i]) issue(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d);
        wait_idle();

        // Both ports request continuously; last grant so far was port 0.
        // Grant port 1 once so the tie starts with port 0 winning.
        issue(1'b1, 1'b1, 7'h30, 32'h0BADF00D);
        wait_idle();
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h0A; wdata0 = 32'h00000A0A;
        req1 = 1'b1; we1 = 1'b1; addr1 = 7'h14; wdata1 = 32'h00001414;
        nlog = 0; saw_g1 = 1'b0;
        for (int i = 0; i < 60 && nlog < 6; i++) begin
            @(negedge clk);
            if (gnt1) saw_g1 = 1'b1;
            if (gnt0) begin log_q.push_back(1'b0); nlog++; end
            else if (gnt1) begin log_q.push_back(1'b1); nlog++; end
        end
        @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
        chk("order_count", nlog, 32'd6);
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        chk("fixed_no_gnt1", {31'd0, saw_g1}, 32'd0);
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk($sformatf("order_%0d", i), {31'd0, log_q[i]}, {31'd0, exp_order[i]});
        wait_idle();

        // Write data changed after grant must not reach the access.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'h03; wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        chk("lit_hold_gnt0", {31'd0, gnt0}, 32'd1);
        @(posedge clk); #1 req0 = 1'b0; wdata0 = 32'h0;
        @(negedge clk);
        chk("lit_hold_cs", {31'd0, mem_cs}, 32'd1);
        chk("lit_hold_data", mem_wdata, 32'hCAFEF00D);
        wait_idle();

        // Reset during RDWAIT of a port 0 read, with port 1 pending.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'h05;
        @(negedge clk);
        chk("lit_rst_gnt0", {31'd0, gnt0}, 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 7'h05;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("lit_rst_busy", {31'd0, busy}, 32'd0);
        chk("lit_rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("lit_rst_addr", {25'd0, mem_addr}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_post_rst_gnt1", {31'd0, gnt1}, 32'd1);
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lit_post_rst_rdata", rdata, 32'hDEADBEEF);
        chk("lit_post_rst_rvalid1", {31'd0, rvalid1}, 32'd1);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
